// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the two-requester memory arbiter.
// Contents: FSM state encoding, requester index constants and the winner-select
// rule. Build option: define MEM_ARB_RR_EN for round-robin arbitration; without
// it the data cache (requester 1) always wins a conflict.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    localparam logic REQ_I = 1'b0;  // instruction cache
    localparam logic REQ_D = 1'b1;  // data cache

    // Returns the index of the winning requester. A lone request always wins;
    // under conflict the preferred requester wins.
    function automatic logic arb_pick(input logic [1:0] valid, input logic ptr);
        logic pref;
`ifdef MEM_ARB_RR_EN
        pref = ptr;
`else
        pref = ptr | REQ_D;  // preference pinned to the data cache
`endif
        return (valid == 2'b11) ? pref : valid[REQ_D];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-input winner select.
// Ports: i_valid - request valid per requester; i_ptr - preferred requester
// under conflict; o_win - index of the winning requester.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic       o_win
);

    assign o_win = arb_pick(i_valid, i_ptr);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-cache (0) and data-cache (1) line requests
// onto a single memory port, one transaction outstanding at a time.
// Ports: clk/reset (sync, active-high); r_valid/r_read/r_write/r_addr*/r_din*
// requester side, r_accept/r_resp pulses and shared r_dout; m_* memory request
// with m_ready handshake and m_out_valid/m_dout read return; conflict_count
// saturating count of IDLE conflicts; timeout_err sticky WAIT_RD timeout flag.
// Build option: MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_SIZE = 16,
    parameter int TIMEOUT   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             r_valid,
    input  logic [1:0]             r_read,
    input  logic [1:0]             r_write,
    input  logic [31:0]            r_addr0,
    input  logic [31:0]            r_addr1,
    input  logic [LINE_SIZE*8-1:0] r_din0,
    input  logic [LINE_SIZE*8-1:0] r_din1,
    output logic [1:0]             r_accept,
    output logic [1:0]             r_resp,
    output logic [LINE_SIZE*8-1:0] r_dout,
    output logic                   m_valid,
    output logic                   m_read,
    output logic                   m_write,
    output logic [31:0]            m_addr,
    output logic [LINE_SIZE*8-1:0] m_din,
    input  logic                   m_ready,
    input  logic                   m_out_valid,
    input  logic [LINE_SIZE*8-1:0] m_dout,
    output logic [31:0]            conflict_count,
    output logic                   timeout_err
);

    state_t      r_state;
    logic        r_win;
    logic        r_ptr;
    logic [31:0] r_wait_cnt;
    logic        w_win;
    logic        w_wr;
    logic        w_rd;

    mem_arb_pick u_pick (
        .i_valid (r_valid),
        .i_ptr   (r_ptr),
        .o_win   (w_win)
    );

    assign w_wr = r_write[w_win];
    assign w_rd = r_read[w_win];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_win          <= 1'b0;
            r_ptr          <= 1'b0;
            r_wait_cnt     <= '0;
            r_accept       <= '0;
            r_resp         <= '0;
            r_dout         <= '0;
            m_valid        <= 1'b0;
            m_read         <= 1'b0;
            m_write        <= 1'b0;
            m_addr         <= '0;
            m_din          <= '0;
            conflict_count <= '0;
            timeout_err    <= 1'b0;
        end else begin
            r_accept <= '0;
            r_resp   <= '0;
            case (r_state)
                IDLE: if (|r_valid) begin
                    r_win    <= w_win;
                    r_accept <= {w_win, ~w_win};
                    m_addr   <= w_win ? r_addr1 : r_addr0;
                    m_din    <= w_win ? r_din1 : r_din0;
                    m_write  <= w_wr;
                    m_read   <= w_rd & ~w_wr;  // write wins when both are set
                    m_valid  <= w_wr | w_rd;
                    if (&r_valid) begin
                        r_ptr <= ~w_win;
                        if (~&conflict_count) conflict_count <= conflict_count + 32'd1;
                    end
                    // a request with neither read nor write is acknowledged and dropped
                    if (w_wr | w_rd) r_state <= ISSUE;
                    else r_resp <= {w_win, ~w_win};
                end
                ISSUE: if (m_ready) begin
                    r_wait_cnt <= '0;
                    if (m_write) begin
                        r_resp  <= {r_win, ~r_win};
                        m_valid <= 1'b0;
                        m_write <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (m_out_valid) begin
                        r_dout  <= m_dout;
                        r_resp  <= {r_win, ~r_win};
                        m_valid <= 1'b0;
                        m_read  <= 1'b0;
                        r_state <= IDLE;
                    end
                    if (TIMEOUT > 0 && r_wait_cnt == 32'(TIMEOUT - 1)) timeout_err <= 1'b1;
                    if (~&r_wait_cnt) r_wait_cnt <= r_wait_cnt + 32'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (TIMEOUT=8).
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   r_valid, r_read, r_write;
    logic [31:0]  r_addr0, r_addr1;
    logic [127:0] r_din0, r_din1;
    logic [1:0]   r_accept, r_resp;
    logic [127:0] r_dout;
    logic         m_valid, m_read, m_write;
    logic [31:0]  m_addr;
    logic [127:0] m_din;
    logic         m_ready, m_out_valid;
    logic [127:0] m_dout;
    logic [31:0]  conflict_count;
    logic         timeout_err;

    typedef struct packed {
        logic [1:0]   who;
        logic         rd;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_SIZE(16), .TIMEOUT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .r_valid        (r_valid),
        .r_read         (r_read),
        .r_write        (r_write),
        .r_addr0        (r_addr0),
        .r_addr1        (r_addr1),
        .r_din0         (r_din0),
        .r_din1         (r_din1),
        .r_accept       (r_accept),
        .r_resp         (r_resp),
        .r_dout         (r_dout),
        .m_valid        (m_valid),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_addr         (m_addr),
        .m_din          (m_din),
        .m_ready        (m_ready),
        .m_out_valid    (m_out_valid),
        .m_dout         (m_dout),
        .conflict_count (conflict_count),
        .timeout_err    (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits up to budget cycles for a response, then compares it with the oldest expectation.
    task automatic expect_resp(input string tag, input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (r_resp == 2'b00 && n < budget) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        check({tag, "_resp"}, 128'(r_resp), 128'(e.who));
        if (e.rd) check({tag, "_dout"}, r_dout, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [3:0]   grants;
        logic [127:0] data;
`ifdef MEM_ARB_RR_EN
        grants = 4'b1010;
`else
        grants = 4'b1111;
`endif
        reset = 1'b1; r_valid = '0; r_read = '0; r_write = '0;
        r_addr0 = '0; r_addr1 = '0; r_din0 = '0; r_din1 = '0;
        m_ready = 1'b0; m_out_valid = 1'b0; m_dout = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_m_valid", 128'(m_valid), 128'(1'b0));
        check("rst_accept", 128'(r_accept), 128'(2'b00));
        check("rst_resp", 128'(r_resp), 128'(2'b00));
        check("rst_dout", r_dout, 128'h0);
        check("rst_conflict", 128'(conflict_count), 128'h0);
        check("rst_timeout", 128'(timeout_err), 128'(1'b0));

        // single read from the instruction cache
        r_valid = 2'b01; r_read = 2'b01; r_addr0 = 32'h10;
        sb.push_back('{2'b01, 1'b1, {16{8'hAB}}});
        tick();
        r_valid = '0; r_read = '0;
        check("rd_accept", 128'(r_accept), 128'(2'b01));
        check("rd_m_valid", 128'(m_valid), 128'(1'b1));
        check("rd_m_addr", 128'(m_addr), 128'h10);
        check("rd_kind", 128'({m_read, m_write}), 128'(2'b10));
        m_out_valid = 1'b1; m_dout = {16{8'hDE}};
        tick();
        m_out_valid = 1'b0;
        check("rd_stray_resp", 128'(r_resp), 128'(2'b00));
        check("rd_hold", 128'(m_valid), 128'(1'b1));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("rd_wait", 128'({m_valid, m_read}), 128'(2'b11));
        m_out_valid = 1'b1; m_dout = {16{8'hAB}};
        tick();
        m_out_valid = 1'b0; m_dout = '0;
        expect_resp("rd", 0);
        check("rd_idle", 128'(m_valid), 128'(1'b0));

        // write from the data cache with a slow memory
        r_valid = 2'b10; r_write = 2'b10; r_addr1 = 32'h20; r_din1 = 128'h1234;
        sb.push_back('{2'b10, 1'b0, 128'h0});
        tick();
        r_valid = '0; r_write = '0;
        check("wr_accept", 128'(r_accept), 128'(2'b10));
        check("wr_kind", 128'({m_read, m_write}), 128'(2'b01));
        check("wr_din", m_din, 128'h1234);
        check("wr_addr", 128'(m_addr), 128'h20);
        for (int i = 0; i < 5; i++) begin
            check("wr_hold", 128'(m_valid), 128'(1'b1));
            check("wr_no_resp", 128'(r_resp), 128'(2'b00));
            if (i < 4) tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        expect_resp("wr", 0);
        check("wr_idle", 128'(m_valid), 128'(1'b0));

        // back-to-back conflicts
        r_valid = 2'b11; r_read = 2'b11; r_addr0 = 32'h100; r_addr1 = 32'h200;
        for (int t = 0; t < 4; t++) begin
            data = {16{8'(8'h11 * (t + 1))}};
            sb.push_back('{grants[t] ? 2'b10 : 2'b01, 1'b1, data});
            tick();
            check("cf_accept", 128'(r_accept), 128'(grants[t] ? 2'b10 : 2'b01));
            check("cf_addr", 128'(m_addr), grants[t] ? 128'h200 : 128'h100);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            m_out_valid = 1'b1; m_dout = data;
            tick();
            m_out_valid = 1'b0;
            expect_resp("cf", 0);
        end
        r_valid = 2'b01; r_read = 2'b01;
        sb.push_back('{2'b01, 1'b1, {16{8'h77}}});
        tick();
        r_valid = '0; r_read = '0;
        check("cf_last_accept", 128'(r_accept), 128'(2'b01));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        m_out_valid = 1'b1; m_dout = {16{8'h77}};
        tick();
        m_out_valid = 1'b0;
        expect_resp("cf_last", 0);
        check("cf_count", 128'(conflict_count), 128'h4);

        // read and write both set is a write
        r_valid = 2'b01; r_read = 2'b01; r_write = 2'b01; r_addr0 = 32'h30; r_din0 = 128'h55;
        sb.push_back('{2'b01, 1'b0, 128'h0});
        tick();
        r_valid = '0; r_read = '0; r_write = '0;
        check("rw_kind", 128'({m_read, m_write}), 128'(2'b01));
        check("rw_din", m_din, 128'h55);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        expect_resp("rw", 0);

        // neither read nor write: acknowledged and dropped
        r_valid = 2'b10;
        sb.push_back('{2'b10, 1'b0, 128'h0});
        tick();
        r_valid = '0;
        check("drop_accept", 128'(r_accept), 128'(2'b10));
        expect_resp("drop", 0);
        check("drop_no_mem", 128'(m_valid), 128'(1'b0));
        tick();
        check("drop_quiet", 128'({m_valid, r_resp, r_accept}), 128'h0);

        // reset while waiting for read data
        r_valid = 2'b01; r_read = 2'b01; r_addr0 = 32'h40;
        tick();
        r_valid = '0; r_read = '0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("rst_mid_wait", 128'({m_valid, m_read}), 128'(2'b11));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_valid", 128'(m_valid), 128'(1'b0));
        check("rst_mid_count", 128'(conflict_count), 128'h0);
        m_out_valid = 1'b1; m_dout = {16{8'h99}};
        tick();
        m_out_valid = 1'b0;
        check("rst_late_resp", 128'(r_resp), 128'(2'b00));
        tick();
        check("rst_late_resp2", 128'(r_resp), 128'(2'b00));

        // timeout with no read data
        r_valid = 2'b01; r_read = 2'b01; r_addr0 = 32'h50;
        tick();
        r_valid = '0; r_read = '0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (7) tick();
        check("to_before", 128'(timeout_err), 128'(1'b0));
        tick();
        check("to_set", 128'(timeout_err), 128'(1'b1));
        repeat (3) tick();
        check("to_sticky", 128'(timeout_err), 128'(1'b1));
        check("to_still_wait", 128'(m_valid), 128'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("to_cleared", 128'(timeout_err), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
